// File: rtl/snake_score_counter.sv
// Adds POINTS_PER_FOOD to a 4-digit BCD score one digit per cycle; score/high score update 6 cycles after an idle event.
// No backpressure: up to PEND_MAX events queue while an addition runs, further events are dropped and flagged.
module snake_score_counter #(
    parameter int SCORE_WIDTH     = 14,
    parameter int POINTS_PER_FOOD = 1,
    parameter int PEND_MAX        = 3
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_n,
    input  logic                   i_Eat,
    input  logic                   i_GameStart,
    input  logic                   i_GameOver,
    output logic [SCORE_WIDTH-1:0] o_Score,
    output logic [15:0]            o_ScoreBCD,
    output logic [SCORE_WIDTH-1:0] o_HighScore,
    output logic                   o_Busy,
    output logic                   o_Updated,
    output logic                   o_Dropped,
    output logic                   o_Saturated
);

    typedef enum logic [1:0] {S_IDLE, S_ADD, S_COMMIT} state_t;

    localparam logic [1:0] LP_PEND_MAX = PEND_MAX[1:0];
    localparam logic [3:0] LP_POINTS   = POINTS_PER_FOOD[3:0];

    state_t                 r_state;
    logic [1:0]             r_pend;
    logic [1:0]             r_k;
    logic                   r_carry;
    logic [3:0][3:0]        r_dig;
    logic [SCORE_WIDTH-1:0] r_score;
    logic [SCORE_WIDTH-1:0] r_high;
    logic [15:0]            r_bcd;
    logic                   r_upd;
    logic                   r_drop;
    logic                   r_sat;

    logic                   w_accept;
    logic                   w_start;
    logic [3:0]             w_addend;
    logic [4:0]             w_sum;
    logic                   w_cout;
    logic [3:0]             w_digit;
    logic [SCORE_WIDTH-1:0] w_bin;

    assign w_accept = i_Eat & ~i_GameOver & ~i_GameStart;
    assign w_start  = (r_state == S_IDLE) && (r_pend != 2'd0);

    // Points enter at the units digit only; higher digits see just the carry.
    assign w_addend = (r_k == 2'd0) ? LP_POINTS : 4'd0;
    assign w_sum    = {1'b0, r_dig[r_k]} + {1'b0, w_addend} + {4'd0, r_carry};
    assign w_cout   = (w_sum > 5'd9);
    assign w_digit  = w_cout ? (w_sum[3:0] - 4'd10) : w_sum[3:0];

    assign w_bin = SCORE_WIDTH'(r_dig[3]) * SCORE_WIDTH'(1000)
                 + SCORE_WIDTH'(r_dig[2]) * SCORE_WIDTH'(100)
                 + SCORE_WIDTH'(r_dig[1]) * SCORE_WIDTH'(10)
                 + SCORE_WIDTH'(r_dig[0]);

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state <= S_IDLE;
            r_pend  <= 2'd0;
            r_k     <= 2'd0;
            r_carry <= 1'b0;
            r_dig   <= '0;
            r_score <= '0;
            r_high  <= '0;
            r_bcd   <= '0;
            r_upd   <= 1'b0;
            r_drop  <= 1'b0;
            r_sat   <= 1'b0;
        end else begin
            r_upd  <= 1'b0;
            r_drop <= 1'b0;
            if (i_GameStart) begin
                r_state <= S_IDLE;
                r_pend  <= 2'd0;
                r_k     <= 2'd0;
                r_carry <= 1'b0;
                r_dig   <= '0;
                r_score <= '0;
                r_bcd   <= '0;
                r_sat   <= 1'b0;
            end else begin
                if (w_accept && !w_start) begin
                    if (r_pend == LP_PEND_MAX) r_drop <= 1'b1;
                    else                       r_pend <= r_pend + 2'd1;
                end else if (!w_accept && w_start) begin
                    r_pend <= r_pend - 2'd1;
                end

                case (r_state)
                    S_IDLE: begin
                        if (w_start) begin
                            r_state <= S_ADD;
                            r_k     <= 2'd0;
                            r_carry <= 1'b0;
                        end
                    end
                    S_ADD: begin
                        r_dig[r_k] <= w_digit;
                        r_carry    <= w_cout;
                        r_k        <= r_k + 2'd1;
                        if (r_k == 2'd3) begin
                            r_state <= S_COMMIT;
                            // Overflow past 9999 clamps rather than wrapping.
                            if (w_cout) begin
                                r_dig <= 16'h9999;
                                r_sat <= 1'b1;
                            end
                        end
                    end
                    S_COMMIT: begin
                        r_bcd   <= r_dig;
                        r_score <= w_bin;
                        if (w_bin > r_high) r_high <= w_bin;
                        r_upd   <= 1'b1;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign o_Score     = r_score;
    assign o_ScoreBCD  = r_bcd;
    assign o_HighScore = r_high;
    assign o_Busy      = (r_state != S_IDLE) || (r_pend != 2'd0);
    assign o_Updated   = r_upd;
    assign o_Dropped   = r_drop;
    assign o_Saturated = r_sat;

endmodule

// File: doc/snake_score_counter.md
Name: snake_score_counter

Overview:
Score source for the seven-segment scoreboard. Accepts food-eaten event pulses from the game logic and adds POINTS_PER_FOOD to a 4-digit BCD score, one digit per cycle. Publishes the committed score in binary (SCORE_WIDTH) for the scoreboard and in packed BCD, and tracks a session high score. Events arriving while an addition is in flight are buffered in a small pending counter.

Parameters:
SCORE_WIDTH, 14, width of binary score outputs (must hold 9999)
POINTS_PER_FOOD, 1, points added per event; legal range 1..9
PEND_MAX, 3, capacity of the pending-event counter (2-bit)

Ports:
i_Clk  input  1  system clock
i_Rst_n  input  1  asynchronous active-low reset
i_Eat  input  1  single-cycle food-eaten pulse
i_GameStart  input  1  single-cycle pulse; clears current score
i_GameOver  input  1  level; while high, new i_Eat pulses are ignored
o_Score  output  SCORE_WIDTH  committed score, binary, to scoreboard
o_ScoreBCD  output  16  committed score, packed BCD, digit 3 = [15:12]
o_HighScore  output  SCORE_WIDTH  highest committed score since reset, binary
o_Busy  output  1  high while FSM is not IDLE or pending > 0
o_Updated  output  1  one-cycle pulse after each commit
o_Dropped  output  1  one-cycle pulse when an i_Eat is lost (pending full)
o_Saturated  output  1  sticky; set when score clamps at 9999

Behaviour:
- Reset (i_Rst_n low, async): all outputs 0, working digits 0, pending 0, FSM IDLE, high score 0.
- Pending counter: +1 on accepted i_Eat (i_Eat & ~i_GameOver & ~i_GameStart); -1 when FSM leaves IDLE; both in same cycle -> unchanged; i_Eat accepted at PEND_MAX with no simultaneous decrement -> counter stays at PEND_MAX, o_Dropped pulses next cycle.
- FSM states: IDLE, ADD, COMMIT.
  - IDLE: if pending > 0 -> ADD, digit index k=0, carry=0, addend=POINTS_PER_FOOD.
  - ADD: each cycle, s = digit[k] + (k==0 ? POINTS_PER_FOOD : 0) + carry; if s > 9 then digit[k] = s - 10, carry = 1, else digit[k] = s, carry = 0; k increments. After k=3 -> COMMIT. If carry out of digit 3 is 1, working digits forced to 9999 and o_Saturated set.
  - COMMIT: copy working digits to o_ScoreBCD, binary equivalent to o_Score, o_HighScore = max(o_HighScore, new score); o_Updated pulses the following cycle; -> IDLE.
- Latency: i_Eat sampled at edge n with FSM idle and pending 0 -> pending=1 at n, ADD at n+1, digits written n+2..n+5, COMMIT entered n+5, outputs updated at edge n+6, o_Updated high in cycle n+6..n+7. Back-to-back events: one commit every 6 cycles.
- Binary o_Score derived from the BCD digits (d3*1000 + d2*100 + d1*10 + d0), registered at commit; never disagrees with o_ScoreBCD.
- Saturation: at 9999 further accepted events still run the FSM and pulse o_Updated; score stays 9999.
- i_GameStart (synchronous): working digits, o_Score, o_ScoreBCD, pending, o_Saturated cleared; FSM forced to IDLE (aborts in-flight addition, no commit, no o_Updated); o_HighScore retained. Same-cycle i_Eat is discarded (not counted as dropped).
- i_GameOver high: new i_Eat ignored, not dropped-flagged; pending and in-flight events still complete and commit.
- o_Busy combinational from FSM state and pending count.

Test Plan:
- Reset, then single i_Eat with POINTS_PER_FOOD=1 -> o_Score=1, o_ScoreBCD=16'h0001, o_Updated pulse exactly 6 cycles after pulse, o_HighScore=1.
- Preload score 0999 via 999 events, one more i_Eat -> o_ScoreBCD=16'h1000, o_Score=1000 (full carry ripple).
- Five i_Eat on consecutive cycles from idle -> pending saturates at 3, o_Dropped pulses once; final o_Score=4 after four commits.
- POINTS_PER_FOOD=5, score 9998, one i_Eat -> o_Score=9999, o_Saturated=1; further i_Eat -> still 9999, o_Updated pulses.
- Score 42, i_GameStart mid-ADD -> o_Score=0, no o_Updated, o_HighScore stays 42; i_Eat in same cycle as i_GameStart ignored.
- i_GameOver high with 1 pending -> pending commits, subsequent i_Eat ignored, o_Dropped stays 0; async reset mid-ADD -> all outputs 0 immediately.
